// File: rtl/mem_data_resp.sv
// Data-memory responder for the MEMORY stage: one request at a time, LATENCY wait
// states, word-addressed RAM plus a switch input word and an LED/HEX output register.
module mem_data_resp #(
  parameter int                ADDR_W      = 10,
  parameter int                DATA_W      = 32,
  parameter int                LATENCY     = 2,
  parameter logic [ADDR_W-1:0] IO_SW_ADDR  = 10'h3FE,
  parameter logic [ADDR_W-1:0] IO_REG_ADDR = 10'h3FF
) (
  input  logic              mdr_in_clk,
  input  logic              mdr_in_reset,
  input  logic              mdr_in_req_valid,
  output logic              mdr_out_req_ready,
  input  logic              mdr_in_req_we,
  input  logic [ADDR_W-1:0] mdr_in_req_addr,
  input  logic [DATA_W-1:0] mdr_in_req_wdata,
  output logic              mdr_out_resp_valid,
  input  logic              mdr_in_resp_ready,
  output logic [DATA_W-1:0] mdr_out_resp_rdata,
  input  logic [17:0]       mdr_in_SW,
  output logic [DATA_W-1:0] mdr_out_io_reg
);

  if (LATENCY < 0 || LATENCY > 7) begin : g_latency_range_check
    $error("mem_data_resp: LATENCY must be within 0..7");
  end

  localparam logic [2:0] LAT3     = 3'(LATENCY);
  localparam bit         ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] io_reg_q, io_reg_d;
  logic [DATA_W-1:0] ram [2**ADDR_W];

  logic              req_ready;
  logic              accept;
  logic              commit;
  logic              ram_we;
  logic              cm_we;
  logic [ADDR_W-1:0] cm_addr;
  logic [DATA_W-1:0] cm_wdata;

  assign req_ready = ~mdr_in_reset &
                     ((state_q == ST_IDLE) | ((state_q == ST_RESP) & mdr_in_resp_ready));
  assign accept    = mdr_in_req_valid & req_ready;

  // With zero latency the commit edge is the accept edge, so the live request is used.
  assign cm_we    = ZERO_LAT ? mdr_in_req_we    : we_q;
  assign cm_addr  = ZERO_LAT ? mdr_in_req_addr  : addr_q;
  assign cm_wdata = ZERO_LAT ? mdr_in_req_wdata : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (ZERO_LAT) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT3;
          end
        end else if (state_q == ST_RESP && mdr_in_resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = ST_RESP;
          cnt_d   = 3'd0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address decode and response data for the transaction committing this edge.
  always_comb begin
    rdata_d  = rdata_q;
    io_reg_d = io_reg_q;
    ram_we   = 1'b0;
    if (commit) begin
      if (cm_we) begin
        rdata_d = cm_wdata;
        if (cm_addr == IO_REG_ADDR) begin
          io_reg_d = cm_wdata;
        end else if (cm_addr != IO_SW_ADDR) begin
          ram_we = 1'b1;
        end
      end else if (cm_addr == IO_SW_ADDR) begin
        rdata_d = DATA_W'(mdr_in_SW);
      end else if (cm_addr == IO_REG_ADDR) begin
        rdata_d = io_reg_q;
      end else begin
        rdata_d = ram[cm_addr];
      end
    end
  end

  always_ff @(posedge mdr_in_clk) begin
    if (mdr_in_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      rdata_q  <= '0;
      io_reg_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      io_reg_q <= io_reg_d;
    end
  end

  always_ff @(posedge mdr_in_clk) begin
    if (accept) begin
      we_q    <= mdr_in_req_we;
      addr_q  <= mdr_in_req_addr;
      wdata_q <= mdr_in_req_wdata;
    end
  end

  // A store still waiting when reset arrives must never reach the RAM.
  always_ff @(posedge mdr_in_clk) begin
    if (ram_we && !mdr_in_reset) begin
      ram[cm_addr] <= cm_wdata;
    end
  end

  assign mdr_out_req_ready  = req_ready;
  assign mdr_out_resp_valid = (state_q == ST_RESP);
  assign mdr_out_resp_rdata = rdata_q;
  assign mdr_out_io_reg     = io_reg_q;

endmodule

// File: tb/tb_mem_data_resp.sv
// Scoreboard bench for mem_data_resp: one instance with LATENCY=2, one with LATENCY=0,
// checked against a plain memory/IO model for data, io_reg and response timing.
module tb_mem_data_resp;

  localparam logic [9:0] SW_A  = 10'h3FE;
  localparam logic [9:0] REG_A = 10'h3FF;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, resp_valid, resp_ready;
  logic [9:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [31:0] resp_rdata [2];
  logic [31:0] io_reg     [2];
  logic [17:0] sw;

  always #5 clk = ~clk;

  mem_data_resp #(.LATENCY(2)) u_lat2 (
    .mdr_in_clk(clk), .mdr_in_reset(rst),
    .mdr_in_req_valid(req_valid[0]), .mdr_out_req_ready(req_ready[0]),
    .mdr_in_req_we(req_we[0]), .mdr_in_req_addr(req_addr[0]), .mdr_in_req_wdata(req_wdata[0]),
    .mdr_out_resp_valid(resp_valid[0]), .mdr_in_resp_ready(resp_ready[0]),
    .mdr_out_resp_rdata(resp_rdata[0]), .mdr_in_SW(sw), .mdr_out_io_reg(io_reg[0])
  );

  mem_data_resp #(.LATENCY(0)) u_lat0 (
    .mdr_in_clk(clk), .mdr_in_reset(rst),
    .mdr_in_req_valid(req_valid[1]), .mdr_out_req_ready(req_ready[1]),
    .mdr_in_req_we(req_we[1]), .mdr_in_req_addr(req_addr[1]), .mdr_in_req_wdata(req_wdata[1]),
    .mdr_out_resp_valid(resp_valid[1]), .mdr_in_resp_ready(resp_ready[1]),
    .mdr_out_resp_rdata(resp_rdata[1]), .mdr_in_SW(sw), .mdr_out_io_reg(io_reg[1])
  );

  typedef struct {
    logic [31:0] data;
    bit          chk;
    logic [31:0] io;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] mram   [2][1024];
  bit          mknown [2][1024];
  logic [31:0] mio    [2];
  int          rr_mode [2];
  bit          presenting [2];
  logic [31:0] held [2];

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic void chk(input string nm, input int k, input logic [31:0] act,
                              input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (dut %0d): got %h, expected %h", nm, k, act, exp);
    end
  endfunction

  function automatic void fail(input string nm, input int k, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s (dut %0d): got %h, expected no such event", nm, k, act);
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpush(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic void qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // resp_ready: 0 = random, 1 = held high, 2 = held low
  initial begin
    resp_ready = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (rr_mode[k])
          0:       resp_ready[k] = ($urandom_range(0, 3) != 0);
          2:       resp_ready[k] = 1'b0;
          default: resp_ready[k] = 1'b1;
        endcase
      end
    end
  end

  // Monitor: a response is checked when first presented and retired when ready is high.
  initial forever begin
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        presenting[k] = 1'b0;
      end else if (resp_valid[k]) begin
        if (!presenting[k]) begin
          if (qsize(k) == 0) begin
            fail("unexpected response", k, resp_rdata[k]);
          end else begin
            e = qfront(k);
            chk("response cycle", k, 32'(cyc), 32'(e.due));
            if (e.chk) chk("response data", k, resp_rdata[k], e.data);
            chk("io_reg at commit", k, io_reg[k], e.io);
          end
          presenting[k] = 1'b1;
          held[k]       = resp_rdata[k];
        end else begin
          chk("rdata held", k, resp_rdata[k], held[k]);
        end
        if (!resp_ready[k]) begin
          chk("req_ready under backpressure", k, 32'(req_ready[k]), 32'd0);
        end else begin
          presenting[k] = 1'b0;
          if (qsize(k) > 0) qpop(k);
        end
      end else if (presenting[k]) begin
        fail("response withdrawn", k, held[k]);
        presenting[k] = 1'b0;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input int k, input bit we, input logic [9:0] a, input logic [31:0] d,
                       input bit track, output int waits);
    exp_t e;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = d;
    waits = 0;
    @(negedge clk);
    while (!req_ready[k] && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready[k]) begin
      fail("accept timeout", k, 32'(waits));
      req_valid[k] = 1'b0;
      return;
    end
    if (track) begin
      e.due = cyc + 1 + lat(k);
      e.chk = 1'b1;
      if (we) begin
        e.data = d;
        if (a == REG_A) mio[k] = d;
        else if (a != SW_A) begin
          mram[k][a]   = d;
          mknown[k][a] = 1'b1;
        end
      end else if (a == SW_A) begin
        e.data = {14'b0, sw};
      end else if (a == REG_A) begin
        e.data = mio[k];
      end else begin
        e.data = mram[k][a];
        e.chk  = mknown[k][a];
      end
      e.io = mio[k];
      qpush(k, e);
    end
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((q0.size() != 0 || q1.size() != 0 || resp_valid != 2'b00) && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) fail("drain timeout", 0, 32'(q0.size() + q1.size()));
    @(posedge clk);
    #2;
  endtask

  task automatic rand_run(input int k, input int count);
    int          w;
    int          r;
    logic [9:0]  a;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 19);
      a = (r < 16) ? 10'(r) : ((r < 18) ? SW_A : REG_A);
      issue(k, 1'($urandom_range(0, 1)), a, $urandom, 1'b1, w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int n;
    rr_mode[0] = 1;
    rr_mode[1] = 1;
    mio[0] = '0;
    mio[1] = '0;
    sw = '0;
    rst = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b11;
    for (int k = 0; k < 2; k++) begin
      req_addr[k]  = REG_A;
      req_wdata[k] = 32'hDEADBEEF;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("req_ready after reset", k, 32'(req_ready[k]), 32'd1);
      chk("resp_valid after reset", k, 32'(resp_valid[k]), 32'd0);
      chk("io_reg after reset", k, io_reg[k], 32'd0);
      chk("rdata after reset", k, resp_rdata[k], 32'd0);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;

    // LATENCY=2 store then load of the same word
    issue(0, 1'b1, 10'd5, 32'h12345678, 1'b1, w);
    issue(0, 1'b0, 10'd5, 32'h0, 1'b1, w);
    drain();

    // Backpressure on a load response
    rr_mode[0] = 2;
    @(posedge clk);
    #2;
    issue(0, 1'b0, 10'd5, 32'h0, 1'b1, w);
    n = 0;
    @(negedge clk);
    while (!resp_valid[0] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!resp_valid[0]) fail("response timeout", 0, 32'(n));
    repeat (4) @(negedge clk);
    rr_mode[0] = 1;
    @(negedge clk);
    @(negedge clk);
    chk("idle after retire resp_valid", 0, 32'(resp_valid[0]), 32'd0);
    chk("idle after retire req_ready", 0, 32'(req_ready[0]), 32'd1);
    drain();

    // LATENCY=0 back-to-back store/load
    issue(1, 1'b1, 10'd7, 32'h0000000A, 1'b1, w);
    issue(1, 1'b0, 10'd7, 32'h0, 1'b1, w);
    chk("back-to-back accept waits", 1, 32'(w), 32'd0);
    drain();

    // I/O words on both instances
    sw = 18'h2ABCD;
    for (int k = 0; k < 2; k++) begin
      issue(k, 1'b0, SW_A, 32'h0, 1'b1, w);
      issue(k, 1'b1, REG_A, 32'h000000FF, 1'b1, w);
      issue(k, 1'b0, REG_A, 32'h0, 1'b1, w);
      issue(k, 1'b1, SW_A, 32'h55555555, 1'b1, w);
      issue(k, 1'b0, SW_A, 32'h0, 1'b1, w);
    end
    drain();

    // Reset while a store is waiting: dropped, never committed
    issue(0, 1'b1, 10'd9, 32'h00000011, 1'b1, w);
    drain();
    issue(0, 1'b1, 10'd9, 32'h00000022, 1'b0, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mio[0] = '0;
    mio[1] = '0;
    repeat (6) @(negedge clk);
    chk("io_reg cleared by reset", 0, io_reg[0], 32'd0);
    @(posedge clk);
    #1;
    issue(0, 1'b0, 10'd9, 32'h0, 1'b1, w);
    drain();

    // Randomized traffic on both instances in parallel
    sw = 18'($urandom);
    rr_mode[0] = 0;
    rr_mode[1] = 0;
    @(posedge clk);
    #2;
    fork
      rand_run(0, 80);
      rand_run(1, 80);
    join
    rr_mode[0] = 1;
    rr_mode[1] = 1;
    drain();
    chk("scoreboard empty", 0, 32'(q0.size()), 32'd0);
    chk("scoreboard empty", 1, 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
